alu_issue_queue: RTL and testbench

Age-ordered issue queue and scheduler for the single shared ALU in the out-of-order core. It accepts renamed ALU micro-ops from dispatch and tracks operand readiness using physical-register wakeup broadcasts. Each cycle it selects the oldest ready entry, reads its operands from the physical register file (PRF), drives the combinational ALU, and registers the result for writeback and wakeup.

---
 rtl/alu_issue_queue_if.sv | 63 ++++++
 rtl/alu_issue_queue.sv | 180 ++++++++++++++++++
 tb/tb_alu_issue_queue.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// Bundle of dispatch, wakeup, PRF-read, ALU and writeback signals between
// the ALU issue queue and its surroundings. The slave modport is the queue.
interface alu_issue_queue_if #(
  parameter int WORD_SIZE   = 32,
  parameter int PREG_BITS   = 6,
  parameter int ALU_OP_SIZE = 4
);
  logic                   flush_i;

  logic                   dispatch_valid_i;
  logic                   dispatch_ready_o;
  logic [ALU_OP_SIZE-1:0] dispatch_alu_op_i;
  logic [PREG_BITS-1:0]   dispatch_prs1_i;
  logic                   dispatch_prs1_ready_i;
  logic [PREG_BITS-1:0]   dispatch_prs2_i;
  logic                   dispatch_prs2_ready_i;
  logic                   dispatch_use_imm_i;
  logic [WORD_SIZE-1:0]   dispatch_imm_i;
  logic [PREG_BITS-1:0]   dispatch_prd_i;

  logic                   wakeup_valid_i;
  logic [PREG_BITS-1:0]   wakeup_preg_i;

  logic [PREG_BITS-1:0]   prf_raddr0_o;
  logic [PREG_BITS-1:0]   prf_raddr1_o;
  logic [WORD_SIZE-1:0]   prf_rdata0_i;
  logic [WORD_SIZE-1:0]   prf_rdata1_i;

  logic [ALU_OP_SIZE-1:0] alu_op_o;
  logic [WORD_SIZE-1:0]   alu_data0_o;
  logic [WORD_SIZE-1:0]   alu_data1_o;
  logic [WORD_SIZE-1:0]   alu_result_i;

  logic                   wb_valid_o;
  logic [PREG_BITS-1:0]   wb_prd_o;
  logic [WORD_SIZE-1:0]   wb_data_o;

  // Environment side: dispatch, wakeup source, PRF and ALU models
  modport master (
    output flush_i,
    output dispatch_valid_i, dispatch_alu_op_i, dispatch_prs1_i,
    output dispatch_prs1_ready_i, dispatch_prs2_i, dispatch_prs2_ready_i,
    output dispatch_use_imm_i, dispatch_imm_i, dispatch_prd_i,
    output wakeup_valid_i, wakeup_preg_i,
    output prf_rdata0_i, prf_rdata1_i, alu_result_i,
    input  dispatch_ready_o, prf_raddr0_o, prf_raddr1_o,
    input  alu_op_o, alu_data0_o, alu_data1_o,
    input  wb_valid_o, wb_prd_o, wb_data_o
  );

  // Issue queue side
  modport slave (
    input  flush_i,
    input  dispatch_valid_i, dispatch_alu_op_i, dispatch_prs1_i,
    input  dispatch_prs1_ready_i, dispatch_prs2_i, dispatch_prs2_ready_i,
    input  dispatch_use_imm_i, dispatch_imm_i, dispatch_prd_i,
    input  wakeup_valid_i, wakeup_preg_i,
    input  prf_rdata0_i, prf_rdata1_i, alu_result_i,
    output dispatch_ready_o, prf_raddr0_o, prf_raddr1_o,
    output alu_op_o, alu_data0_o, alu_data1_o,
    output wb_valid_o, wb_prd_o, wb_data_o
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Age-ordered collapsing issue queue for the shared ALU. Entry 0 is the
// oldest; the oldest ready entry issues each cycle, reads the PRF, drives the
// ALU, and its result is registered for writeback and own-wakeup.
module alu_issue_queue #(
  parameter int WORD_SIZE   = 32,
  parameter int NUM_P_REGS  = 64,
  parameter int PREG_BITS   = 6,
  parameter int ALU_OP_SIZE = 4,
  parameter int IQ_DEPTH    = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  alu_issue_queue_if.slave bus
);

  localparam int IDX_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic                   valid;
    logic [ALU_OP_SIZE-1:0] op;
    logic [PREG_BITS-1:0]   prs1;
    logic                   r1;
    logic [PREG_BITS-1:0]   prs2;
    logic                   r2;
    logic                   use_imm;
    logic [WORD_SIZE-1:0]   imm;
    logic [PREG_BITS-1:0]   prd;
  } entry_t;

  entry_t               ent_q [IQ_DEPTH];
  entry_t               ent_w [IQ_DEPTH];   // after this cycle's wakeups
  entry_t               ent_d [IQ_DEPTH];   // after wakeup, collapse, dispatch
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 wb_valid_q;
  logic [PREG_BITS-1:0] wb_prd_q;
  logic [WORD_SIZE-1:0] wb_data_q;

  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_idx;
  logic [IQ_DEPTH-1:0]  shift_mask;
  entry_t               sel_ent;
  logic                 disp_ready;
  logic                 disp_fire;
  logic [CNT_W-1:0]     wr_idx;
  entry_t               disp_ent;

  // A source becomes ready on the external broadcast or on our own writeback
  function automatic logic tag_hit(input logic [PREG_BITS-1:0] tag,
                                   input logic wk_v, input logic [PREG_BITS-1:0] wk_tag,
                                   input logic wb_v, input logic [PREG_BITS-1:0] wb_tag);
    return (wk_v && (tag == wk_tag)) || (wb_v && (tag == wb_tag));
  endfunction

  // Ready depends only on registered occupancy, never on this cycle's issue
  assign disp_ready = (count_q < CNT_W'(IQ_DEPTH));
  assign disp_fire  = bus.dispatch_valid_i && disp_ready;
  assign wr_idx     = count_q - CNT_W'(sel_valid);
  assign count_d    = count_q + CNT_W'(disp_fire) - CNT_W'(sel_valid);

  // Build the incoming entry with readiness captured from same-cycle wakeups
  always_comb begin
    disp_ent         = '0;
    disp_ent.valid   = 1'b1;
    disp_ent.op      = bus.dispatch_alu_op_i;
    disp_ent.prs1    = bus.dispatch_prs1_i;
    disp_ent.prs2    = bus.dispatch_prs2_i;
    disp_ent.use_imm = bus.dispatch_use_imm_i;
    disp_ent.imm     = bus.dispatch_imm_i;
    disp_ent.prd     = bus.dispatch_prd_i;
    disp_ent.r1      = bus.dispatch_prs1_ready_i || (bus.dispatch_prs1_i == '0) ||
                       tag_hit(bus.dispatch_prs1_i, bus.wakeup_valid_i, bus.wakeup_preg_i,
                               wb_valid_q, wb_prd_q);
    disp_ent.r2      = bus.dispatch_prs2_ready_i || (bus.dispatch_prs2_i == '0) ||
                       bus.dispatch_use_imm_i ||
                       tag_hit(bus.dispatch_prs2_i, bus.wakeup_valid_i, bus.wakeup_preg_i,
                               wb_valid_q, wb_prd_q);
  end

  // Oldest-ready select; entries at and above the winner shift down on issue
  always_comb begin
    sel_valid  = 1'b0;
    sel_idx    = '0;
    shift_mask = '0;
    for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].r1 && ent_q[i].r2) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < IQ_DEPTH; i++) begin
      shift_mask[i] = sel_valid && (i >= int'(sel_idx));
    end
  end

  assign sel_ent = ent_q[sel_idx];

  // With no winner sel_idx is 0, so the addresses fall back to entry 0
  assign bus.prf_raddr0_o     = ent_q[sel_idx].valid ? sel_ent.prs1 : '0;
  assign bus.prf_raddr1_o     = ent_q[sel_idx].valid ? sel_ent.prs2 : '0;
  assign bus.alu_op_o         = sel_valid ? sel_ent.op : '0;
  assign bus.alu_data0_o      = bus.prf_rdata0_i;
  assign bus.alu_data1_o      = sel_ent.use_imm ? sel_ent.imm : bus.prf_rdata1_i;
  assign bus.dispatch_ready_o = disp_ready;
  assign bus.wb_valid_o       = wb_valid_q;
  assign bus.wb_prd_o         = wb_prd_q;
  assign bus.wb_data_o        = wb_data_q;

  genvar gi;
  generate
    for (gi = 0; gi < IQ_DEPTH; gi++) begin : g_entry
      entry_t woken;
      entry_t above;

      // Apply external and own-writeback wakeups to this slot
      always_comb begin
        woken    = ent_q[gi];
        woken.r1 = ent_q[gi].r1 ||
                   tag_hit(ent_q[gi].prs1, bus.wakeup_valid_i, bus.wakeup_preg_i,
                           wb_valid_q, wb_prd_q);
        woken.r2 = ent_q[gi].r2 ||
                   tag_hit(ent_q[gi].prs2, bus.wakeup_valid_i, bus.wakeup_preg_i,
                           wb_valid_q, wb_prd_q);
      end
      assign ent_w[gi] = woken;

      if (gi < IQ_DEPTH - 1) begin : g_mid
        assign above = ent_w[gi+1];
      end else begin : g_top
        assign above = '0;
      end

      assign ent_d[gi] = (disp_fire && (wr_idx == CNT_W'(gi))) ? disp_ent :
                         shift_mask[gi] ? above : ent_w[gi];
    end
  endgenerate

  // Queue storage and occupancy; flush empties the queue and drops dispatch
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      count_q <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  // Writeback register; tag and data hold when nothing issues
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_q <= 1'b0;
      wb_prd_q   <= '0;
      wb_data_q  <= '0;
    end else if (bus.flush_i) begin
      wb_valid_q <= 1'b0;
    end else if (sel_valid) begin
      wb_valid_q <= 1'b1;
      wb_prd_q   <= sel_ent.prd;
      wb_data_q  <= bus.alu_result_i;
    end else begin
      wb_valid_q <= 1'b0;
    end
  end

  // Occupancy must stay within 0..IQ_DEPTH and tags must cover the PRF
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (NUM_P_REGS == (1 << PREG_BITS));
      assert (count_q <= CNT_W'(IQ_DEPTH));
      assert (!(sel_valid && (count_q == '0)));
      assert (!(disp_fire && !sel_valid && (count_q == CNT_W'(IQ_DEPTH))));
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a small PRF and ALU model.
module tb_alu_issue_queue;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_issue_queue_if bus ();

  alu_issue_queue dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // PRF model: reset contents are p5=7, p6=3, otherwise pN=N; written by wb
  logic [31:0] prf [64];

  function automatic logic [31:0] prf_init(input int i);
    if (i == 5) return 32'd7;
    if (i == 6) return 32'd3;
    return 32'(i);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) prf[i] <= prf_init(i);
    end else if (bus.wb_valid_o) begin
      prf[bus.wb_prd_o] <= bus.wb_data_o;
    end
  end

  assign bus.prf_rdata0_i = prf[bus.prf_raddr0_o];
  assign bus.prf_rdata1_i = prf[bus.prf_raddr1_o];

  // ALU model: 2=ADD, 3=SUB, 4=XOR
  assign bus.alu_result_i = (bus.alu_op_o == 4'd2) ? bus.alu_data0_o + bus.alu_data1_o :
                            (bus.alu_op_o == 4'd3) ? bus.alu_data0_o - bus.alu_data1_o :
                            (bus.alu_op_o == 4'd4) ? bus.alu_data0_o ^ bus.alu_data1_o :
                            32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_i               = 1'b0;
    bus.dispatch_valid_i      = 1'b0;
    bus.dispatch_alu_op_i     = '0;
    bus.dispatch_prs1_i       = '0;
    bus.dispatch_prs1_ready_i = 1'b0;
    bus.dispatch_prs2_i       = '0;
    bus.dispatch_prs2_ready_i = 1'b0;
    bus.dispatch_use_imm_i    = 1'b0;
    bus.dispatch_imm_i        = '0;
    bus.dispatch_prd_i        = '0;
    bus.wakeup_valid_i        = 1'b0;
    bus.wakeup_preg_i         = '0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [5:0] p1, input logic r1,
                      input logic [5:0] p2, input logic r2, input logic ui,
                      input logic [31:0] imm, input logic [5:0] prd);
    bus.dispatch_valid_i      = 1'b1;
    bus.dispatch_alu_op_i     = op;
    bus.dispatch_prs1_i       = p1;
    bus.dispatch_prs1_ready_i = r1;
    bus.dispatch_prs2_i       = p2;
    bus.dispatch_prs2_ready_i = r2;
    bus.dispatch_use_imm_i    = ui;
    bus.dispatch_imm_i        = imm;
    bus.dispatch_prd_i        = prd;
  endtask

  task automatic wake(input logic [5:0] tag);
    bus.wakeup_valid_i = 1'b1;
    bus.wakeup_preg_i  = tag;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_wb_valid", 32'(bus.wb_valid_o), 0);
    chk("rst_wb_prd", 32'(bus.wb_prd_o), 0);
    chk("rst_wb_data", bus.wb_data_o, 0);
    chk("rst_ready", 32'(bus.dispatch_ready_o), 1);
    chk("rst_alu_op", 32'(bus.alu_op_o), 0);
    chk("rst_raddr0", 32'(bus.prf_raddr0_o), 0);

    // Ready ADD p5+p6 -> p10: issues E+1, wb visible E+2
    disp(4'd2, 6'd5, 1'b1, 6'd6, 1'b1, 1'b0, 0, 6'd10);
    tick();
    idle();
    chk("t1_alu_op", 32'(bus.alu_op_o), 2);
    chk("t1_raddr0", 32'(bus.prf_raddr0_o), 5);
    chk("t1_raddr1", 32'(bus.prf_raddr1_o), 6);
    chk("t1_data0", bus.alu_data0_o, 7);
    chk("t1_data1", bus.alu_data1_o, 3);
    chk("t1_wb_early", 32'(bus.wb_valid_o), 0);
    tick();
    chk("t1_wb_valid", 32'(bus.wb_valid_o), 1);
    chk("t1_wb_prd", 32'(bus.wb_prd_o), 10);
    chk("t1_wb_data", bus.wb_data_o, 10);
    chk("t1_empty_op", 32'(bus.alu_op_o), 0);
    tick();
    chk("t1_wb_clear", 32'(bus.wb_valid_o), 0);
    chk("t1_wb_hold", 32'(bus.wb_prd_o), 10);

    // A: p11 = p5+p5 = 14; B: p12 = p11 - p0, woken by A's writeback
    disp(4'd2, 6'd5, 1'b1, 6'd5, 1'b1, 1'b0, 0, 6'd11);
    tick();
    chk("t2_a_op", 32'(bus.alu_op_o), 2);
    disp(4'd3, 6'd11, 1'b0, 6'd0, 1'b0, 1'b0, 0, 6'd12);
    tick();
    idle();
    chk("t2_a_wb_prd", 32'(bus.wb_prd_o), 11);
    chk("t2_a_wb_data", bus.wb_data_o, 14);
    chk("t2_b_wait", 32'(bus.alu_op_o), 0);
    tick();
    chk("t2_b_op", 32'(bus.alu_op_o), 3);
    chk("t2_b_raddr0", 32'(bus.prf_raddr0_o), 11);
    chk("t2_b_raddr1", 32'(bus.prf_raddr1_o), 0);
    chk("t2_b_data0", bus.alu_data0_o, 14);
    tick();
    chk("t2_b_wb_prd", 32'(bus.wb_prd_o), 12);
    chk("t2_b_wb_data", bus.wb_data_o, 14);

    // Fill with four ops waiting on p20, imm k+1, dest 21+k
    for (int k = 0; k < 4; k++) begin
      disp(4'd2, 6'd20, 1'b0, 6'd0, 1'b0, 1'b1, 32'(k + 1), 6'(21 + k));
      tick();
    end
    idle();
    chk("t3_full_ready", 32'(bus.dispatch_ready_o), 0);
    chk("t3_full_op", 32'(bus.alu_op_o), 0);
    wake(6'd20);
    tick();
    idle();
    chk("t3_w1_op", 32'(bus.alu_op_o), 2);
    chk("t3_w1_data1", bus.alu_data1_o, 1);
    chk("t3_w1_ready", 32'(bus.dispatch_ready_o), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t3_wb_valid", 32'(bus.wb_valid_o), 1);
      chk("t3_wb_prd", 32'(bus.wb_prd_o), 32'(21 + k));
      chk("t3_wb_data", bus.wb_data_o, 32'(21 + k));
      chk("t3_ready", 32'(bus.dispatch_ready_o), 1);
      tick();
    end
    chk("t3_drain_wb", 32'(bus.wb_valid_o), 0);
    chk("t3_drain_op", 32'(bus.alu_op_o), 0);

    // Older X waits on p30; younger Y ready issues first
    disp(4'd4, 6'd30, 1'b0, 6'd0, 1'b0, 1'b1, 32'd5, 6'd31);
    tick();
    disp(4'd2, 6'd5, 1'b1, 6'd6, 1'b1, 1'b0, 0, 6'd32);
    tick();
    idle();
    chk("t4_y_op", 32'(bus.alu_op_o), 2);
    chk("t4_y_raddr0", 32'(bus.prf_raddr0_o), 5);
    wake(6'd30);
    tick();
    idle();
    chk("t4_y_wb_prd", 32'(bus.wb_prd_o), 32);
    chk("t4_y_wb_data", bus.wb_data_o, 10);
    chk("t4_x_op", 32'(bus.alu_op_o), 4);
    chk("t4_x_raddr0", 32'(bus.prf_raddr0_o), 30);
    chk("t4_x_data1", bus.alu_data1_o, 5);
    tick();
    chk("t4_x_wb_prd", 32'(bus.wb_prd_o), 31);
    chk("t4_x_wb_data", bus.wb_data_o, 27);

    // Dispatch on p9 in the same cycle p9 is broadcast
    disp(4'd2, 6'd9, 1'b0, 6'd0, 1'b0, 1'b0, 0, 6'd33);
    wake(6'd9);
    tick();
    idle();
    chk("t5_op", 32'(bus.alu_op_o), 2);
    chk("t5_raddr0", 32'(bus.prf_raddr0_o), 9);
    tick();
    chk("t5_wb_prd", 32'(bus.wb_prd_o), 33);
    chk("t5_wb_data", bus.wb_data_o, 9);

    // Three ops waiting on p40 plus one ready op, then flush with dispatch
    for (int k = 0; k < 3; k++) begin
      disp(4'd2, 6'd40, 1'b0, 6'd0, 1'b0, 1'b1, 32'(k), 6'(41 + k));
      tick();
    end
    disp(4'd2, 6'd5, 1'b1, 6'd6, 1'b1, 1'b0, 0, 6'd44);
    tick();
    idle();
    chk("t6_r_op", 32'(bus.alu_op_o), 2);
    chk("t6_full_ready", 32'(bus.dispatch_ready_o), 0);
    tick();
    chk("t6_r_wb_valid", 32'(bus.wb_valid_o), 1);
    chk("t6_r_wb_prd", 32'(bus.wb_prd_o), 44);
    chk("t6_pre_ready", 32'(bus.dispatch_ready_o), 1);
    disp(4'd2, 6'd5, 1'b1, 6'd6, 1'b1, 1'b0, 0, 6'd45);
    bus.flush_i = 1'b1;
    tick();
    idle();
    chk("t6_flush_wb", 32'(bus.wb_valid_o), 0);
    chk("t6_flush_ready", 32'(bus.dispatch_ready_o), 1);
    chk("t6_flush_op", 32'(bus.alu_op_o), 0);
    wake(6'd40);
    tick();
    idle();
    chk("t6_dead_op", 32'(bus.alu_op_o), 0);
    chk("t6_dead_wb", 32'(bus.wb_valid_o), 0);
    tick();
    chk("t6_dead_wb2", 32'(bus.wb_valid_o), 0);
    chk("t6_dead_ready", 32'(bus.dispatch_ready_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
